decode_stage: RTL and testbench

Instruction-decode (ID) stage of the 5-stage pipeline. It consumes the IF/ID outputs (instruction, PC+4) and decodes the opcode into control bits. It reads two operands from a 32-entry register file, which is written back from MEM/WB, and sign-extends the 16-bit immediate. All results are registered into the ID/EX latch for the execute stage.

---
 rtl/decode_stage_pkg.sv | 26 ++
 rtl/decode_stage_reg_file.sv | 39 +++
 rtl/decode_stage.sv | 119 +++++++++++
 tb/tb_decode_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared opcode/ALUOp encodings and control-bundle bit positions for the ID stage.
package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // wb bundle = {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // m bundle = {Branch, MemRead, MemWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;
    // ex bundle = {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

endpackage

// File: rtl/decode_stage_reg_file.sv
// 2R/1W register file with $0 hard-wired to zero and write-before-read bypass.
module decode_stage_reg_file #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]     rdata1_o,
    output logic [DATA_W-1:0]     rdata2_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass lets ID/EX capture the value being written back this same edge.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
        if (raddr2_i != '0) rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: control decode, register read, sign-extend, registered into ID/EX.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_id_instr,
    input  logic [DATA_W-1:0]     if_id_npc,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0]     wb_write_data,
    output logic [1:0]            id_ex_wb,
    output logic [2:0]            id_ex_m,
    output logic [3:0]            id_ex_ex,
    output logic [DATA_W-1:0]     id_ex_npc,
    output logic [DATA_W-1:0]     id_ex_rd1,
    output logic [DATA_W-1:0]     id_ex_rd2,
    output logic [DATA_W-1:0]     id_ex_imm,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_rd
);

    logic [5:0]            opcode;
    logic [1:0]            wb_d, wb_q;
    logic [2:0]            m_d, m_q;
    logic [3:0]            ex_d, ex_q;
    logic [DATA_W-1:0]     rd1_d, rd2_d, imm_d;
    logic [DATA_W-1:0]     npc_q, rd1_q, rd2_q, imm_q;
    logic [REG_ADDR_W-1:0] rt_q, rd_q;

    assign opcode = if_id_instr[31:26];

    always_comb begin
        wb_d = '0;
        m_d  = '0;
        ex_d = '0;
        case (opcode)
            OP_RTYPE: begin
                ex_d[EX_REGDST]                = 1'b1;
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
                wb_d[WB_REGWRITE]              = 1'b1;
            end
            OP_LW: begin
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex_d[EX_ALUSRC]                = 1'b1;
                m_d[M_MEMREAD]                 = 1'b1;
                wb_d[WB_REGWRITE]              = 1'b1;
                wb_d[WB_MEMTOREG]              = 1'b1;
            end
            OP_SW: begin
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex_d[EX_ALUSRC]                = 1'b1;
                m_d[M_MEMWRITE]                = 1'b1;
            end
            OP_BEQ: begin
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
                m_d[M_BRANCH]                  = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_d = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};

    decode_stage_reg_file #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .NUM_REGS  (NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wb_reg_write),
        .waddr_i (wb_write_reg),
        .wdata_i (wb_write_data),
        .raddr1_i(if_id_instr[25:21]),
        .raddr2_i(if_id_instr[20:16]),
        .rdata1_o(rd1_d),
        .rdata2_o(rd2_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q  <= '0;
            m_q   <= '0;
            ex_q  <= '0;
            npc_q <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
            imm_q <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
        end else begin
            wb_q  <= wb_d;
            m_q   <= m_d;
            ex_q  <= ex_d;
            npc_q <= if_id_npc;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            imm_q <= imm_d;
            rt_q  <= if_id_instr[20:16];
            rd_q  <= if_id_instr[15:11];
        end
    end

    assign id_ex_wb  = wb_q;
    assign id_ex_m   = m_q;
    assign id_ex_ex  = ex_q;
    assign id_ex_npc = npc_q;
    assign id_ex_rd1 = rd1_q;
    assign id_ex_rd2 = rd2_q;
    assign id_ex_imm = imm_q;
    assign id_ex_rt  = rt_q;
    assign id_ex_rd  = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table plus reset/bypass/$0 sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_id_instr, if_id_npc, wb_write_data;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_imm;
    logic [4:0]  id_ex_rt, id_ex_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_id_instr  (if_id_instr),
        .if_id_npc    (if_id_npc),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .wb_write_data(wb_write_data),
        .id_ex_wb     (id_ex_wb),
        .id_ex_m      (id_ex_m),
        .id_ex_ex     (id_ex_ex),
        .id_ex_npc    (id_ex_npc),
        .id_ex_rd1    (id_ex_rd1),
        .id_ex_rd2    (id_ex_rd2),
        .id_ex_imm    (id_ex_imm),
        .id_ex_rt     (id_ex_rt),
        .id_ex_rd     (id_ex_rd)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wb"},  {30'd0, id_ex_wb}, 32'd0);
        chk({tag, ".m"},   {29'd0, id_ex_m},  32'd0);
        chk({tag, ".ex"},  {28'd0, id_ex_ex}, 32'd0);
        chk({tag, ".npc"}, id_ex_npc, 32'd0);
        chk({tag, ".rd1"}, id_ex_rd1, 32'd0);
        chk({tag, ".rd2"}, id_ex_rd2, 32'd0);
        chk({tag, ".imm"}, id_ex_imm, 32'd0);
        chk({tag, ".rt_rd"}, {22'd0, id_ex_rt, id_ex_rd}, 32'd0);
    endtask

    // Advance one edge, then let outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] npc,
                           input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        if_id_instr   = instr;
        if_id_npc     = npc;
        wb_reg_write  = we;
        wb_write_reg  = wreg;
        wb_write_data = wdata;
    endtask

    initial begin
        //                instr         npc    wb     m       ex       imm          rd1  rd2  rt  rd
        vecs[0] = '{32'h01095020, 32'h08, 2'b10, 3'b000, 4'b1100, 32'h00005020, 32'h5, 32'h0, 5'd9, 5'd10};
        vecs[1] = '{32'h8D09FFFC, 32'h0C, 2'b11, 3'b010, 4'b0001, 32'hFFFFFFFC, 32'h5, 32'h0, 5'd9, 5'd31};
        vecs[2] = '{32'hAD09000C, 32'h10, 2'b00, 3'b001, 4'b0001, 32'h0000000C, 32'h5, 32'h0, 5'd9, 5'd0};
        vecs[3] = '{32'h1109FFFF, 32'h14, 2'b00, 3'b100, 4'b0010, 32'hFFFFFFFF, 32'h5, 32'h0, 5'd9, 5'd31};
        vecs[4] = '{32'hA00000AA, 32'h18, 2'b00, 3'b000, 4'b0000, 32'h000000AA, 32'h0, 32'h0, 5'd0, 5'd0};

        // Reset with garbage on every input
        rst = 1'b1;
        present(32'hFFFFFFFF, 32'hCAFEF00D, 1'b1, 5'd8, 32'hBAADBAAD);
        step();
        step();
        chk_all_zero("reset");

        // Release with a zero instruction: data fields stay 0, R-type control
        rst = 1'b0;
        present(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk("rel.rd1", id_ex_rd1, 32'd0);
        chk("rel.rd2", id_ex_rd2, 32'd0);
        chk("rel.imm", id_ex_imm, 32'd0);
        chk("rel.npc", id_ex_npc, 32'd0);
        chk("rel.ctl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, {23'd0, 2'b10, 3'b000, 4'b1100});

        // $8 = 5 (no bypass involvement: rs=rt=0)
        present(32'h0, 32'h0, 1'b1, 5'd8, 32'h5);
        step();

        for (int i = 0; i < 5; i++) begin
            present(vecs[i].instr, vecs[i].npc, 1'b0, 5'd0, 32'h0);
            step();
            chk($sformatf("v%0d.wb", i),  {30'd0, id_ex_wb}, {30'd0, vecs[i].wb});
            chk($sformatf("v%0d.m", i),   {29'd0, id_ex_m},  {29'd0, vecs[i].m});
            chk($sformatf("v%0d.ex", i),  {28'd0, id_ex_ex}, {28'd0, vecs[i].ex});
            chk($sformatf("v%0d.imm", i), id_ex_imm, vecs[i].imm);
            chk($sformatf("v%0d.rd1", i), id_ex_rd1, vecs[i].rd1);
            chk($sformatf("v%0d.rd2", i), id_ex_rd2, vecs[i].rd2);
            chk($sformatf("v%0d.npc", i), id_ex_npc, vecs[i].npc);
            chk($sformatf("v%0d.rt", i),  {27'd0, id_ex_rt}, {27'd0, vecs[i].rt});
            chk($sformatf("v%0d.rd", i),  {27'd0, id_ex_rd}, {27'd0, vecs[i].rd});
        end

        // $0 write is discarded, both during the write cycle and after
        present(32'h0, 32'h0, 1'b1, 5'd0, 32'hDEADBEEF);
        step();
        chk("r0.same", id_ex_rd1, 32'd0);
        present(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk("r0.after", id_ex_rd1, 32'd0);

        // Same-cycle write of $8 with rs=rt=8 bypasses to both ports
        present(32'h01084020, 32'h20, 1'b1, 5'd8, 32'h00001234);
        step();
        chk("byp.rd1", id_ex_rd1, 32'h00001234);
        chk("byp.rd2", id_ex_rd2, 32'h00001234);
        present(32'h01084020, 32'h24, 1'b0, 5'd8, 32'hFFFF0000);
        step();
        chk("byp.later_rd1", id_ex_rd1, 32'h00001234);
        chk("byp.nowe_rd2", id_ex_rd2, 32'h00001234);

        // Bypass on rt only, rs reads stored $8
        present(32'h01094020, 32'h28, 1'b1, 5'd9, 32'h00000077);
        step();
        chk("bypt.rd1", id_ex_rd1, 32'h00001234);
        chk("bypt.rd2", id_ex_rd2, 32'h00000077);

        // Unknown opcode, then asynchronous reset mid-cycle with a write pending
        present(32'hA10000AA, 32'h2C, 1'b0, 5'd0, 32'h0);
        step();
        chk("unk.ctl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'd0);
        chk("unk.imm", id_ex_imm, 32'h000000AA);
        chk("unk.rd1", id_ex_rd1, 32'h00001234);
        present(32'h01084020, 32'h30, 1'b1, 5'd8, 32'h0000BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst");
        step();
        present(32'h01294820, 32'h34, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        step();
        present(32'h01084020, 32'h38, 1'b0, 5'd0, 32'h0);
        step();
        chk("arst.r8", id_ex_rd1, 32'd0);
        chk("arst.r8b", id_ex_rd2, 32'd0);
        chk("arst.npc", id_ex_npc, 32'h38);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
